// File: rtl/spw_clkgen_multi.sv
// Multi-channel clock/tick generator on a single reference clock. Each channel has a
// programmable divide and phase; any reconfiguration triggers a settle and global realign.
module spw_clkgen_multi #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  typedef enum logic [1:0] {IDLE, SETTLE, RUN} state_t;

  localparam int SC_W = $clog2(LOCK_CYCLES + 1);

  state_t            state, state_nx;
  logic [SC_W-1:0]   settle_cnt;
  logic              xfer, ch_valid, wr_en, settle_done;

  logic [DIV_W-1:0]  div_q   [NUM_CH];
  logic [DIV_W-1:0]  phase_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_q   [NUM_CH];
  logic [DIV_W-1:0]  cnt_nx  [NUM_CH];
  logic [DIV_W-1:0]  ediv    [NUM_CH];
  logic [DIV_W-1:0]  eph     [NUM_CH];

  logic [NUM_CH-1:0] outclk_nx, tick_nx;
  logic              locked_nx, ready_nx;

  assign xfer        = cfg_valid && cfg_ready;
  assign ch_valid    = int'(cfg_ch) < NUM_CH;
  assign wr_en       = xfer && ch_valid;
  assign settle_done = settle_cnt == SC_W'(LOCK_CYCLES - 1);

  // Divides below 2 cannot form a square wave; phase is clamped into the period.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ediv[i] = (div_q[i] < DIV_W'(2)) ? DIV_W'(2) : div_q[i];
      eph[i]  = (phase_q[i] > ediv[i] - DIV_W'(1)) ? ediv[i] - DIV_W'(1) : phase_q[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      state      <= state_nx;
      settle_cnt <= (state == SETTLE && state_nx == SETTLE) ? settle_cnt + SC_W'(1) : '0;
    end
  end

  // NOTE: the default assignment at the top of each combinational block prevents latches.
  always_comb begin
    state_nx = state;
    if (!enable) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (!xfer) state_nx = SETTLE;
        SETTLE:  if (settle_done) state_nx = RUN;
        RUN:     if (wr_en) state_nx = SETTLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Outputs are registered from next-state so the first RUN cycle already shows the phase count.
  always_comb begin
    locked_nx = state_nx == RUN;
    ready_nx  = state_nx != SETTLE;
    outclk_nx = '0;
    tick_nx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (locked_nx && state == RUN)
        cnt_nx[i] = (cnt_q[i] == ediv[i] - DIV_W'(1)) ? '0 : cnt_q[i] + DIV_W'(1);
      else
        cnt_nx[i] = eph[i];
      outclk_nx[i] = locked_nx && (cnt_nx[i] < (ediv[i] >> 1));
      tick_nx[i]   = locked_nx && (cnt_nx[i] == '0);
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      outclk    <= '0;
      tick      <= '0;
      locked    <= 1'b0;
      cfg_ready <= 1'b0;
    end else begin
      outclk    <= outclk_nx;
      tick      <= tick_nx;
      locked    <= locked_nx;
      cfg_ready <= ready_nx;
    end
  end

  // NOTE: the per-channel arrays are configuration registers, not RAM, so they take a reset.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i]   <= DIV_W'(DEF_DIV);
        phase_q[i] <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_nx[i];
        if (wr_en && cfg_ch == CH_W'(i)) begin
          div_q[i]   <= cfg_div;
          phase_q[i] <= cfg_phase;
        end
      end
    end
  end

endmodule

// File: tb/tb_spw_clkgen_multi.sv
// Directed bench for spw_clkgen_multi with three channels (so cfg_ch=3 is out of range).
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_spw_clkgen_multi;

  localparam int NUM_CH = 3;
  localparam int DIV_W  = 8;
  localparam int LOCK   = 16;

  logic             refclk = 1'b0;
  logic             rst_n  = 1'b1;
  logic             enable = 1'b0;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [1:0]       cfg_ch = '0;
  logic [DIV_W-1:0] cfg_div = '0;
  logic [DIV_W-1:0] cfg_phase = '0;
  logic [2:0]       outclk, tick;
  logic             locked;

  int checks = 0;
  int errors = 0;
  int m_div [3];
  int m_ph  [3];

  spw_clkgen_multi #(
    .NUM_CH(NUM_CH), .DIV_W(DIV_W), .LOCK_CYCLES(LOCK), .DEF_DIV(2)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase),
    .outclk(outclk), .tick(tick), .locked(locked)
  );

  always #5 refclk = ~refclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  // Enable is sampled at the next edge E; RUN is visible after edge E+LOCK.
  task automatic settle(input string tag);
    enable = 1'b1;
    step();
    check({tag, "_lk_e"}, locked, 0);
    check({tag, "_rdy_e"}, cfg_ready, 0);
    repeat (LOCK - 1) step();
    check({tag, "_lk_last"}, locked, 0);
    check({tag, "_clk_last"}, outclk, 0);
    step();
  endtask

  // Compares n RUN cycles starting at cycle k0 against a per-channel counter model.
  task automatic run_check(input string tag, input int k0, input int n);
    logic [2:0] eo, et;
    int c;
    for (int k = k0; k < k0 + n; k++) begin
      for (int i = 0; i < 3; i++) begin
        c = (m_ph[i] + k) % m_div[i];
        eo[i] = c < m_div[i] / 2;
        et[i] = c == 0;
      end
      check({tag, "_lk"}, locked, 1);
      check({tag, "_clk"}, outclk, eo);
      check({tag, "_tick"}, tick, et);
      if (k != k0 + n - 1) step();
    end
  endtask

  task automatic write(input logic [1:0] ch, input int d, input int p);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = DIV_W'(d);
    cfg_phase = DIV_W'(p);
    step();
    cfg_valid = 1'b0;
  endtask

  initial begin
    #2 rst_n = 1'b0;
    @(negedge refclk);
    check("rst_clk", outclk, 0);
    check("rst_tick", tick, 0);
    check("rst_lk", locked, 0);
    check("rst_rdy", cfg_ready, 0);
    @(negedge refclk);
    rst_n = 1'b1;
    step();
    check("idle_rdy", cfg_ready, 1);

    // Defaults: all div 2, aligned, toggling every cycle.
    m_div = '{2, 2, 2};
    m_ph  = '{0, 0, 0};
    settle("def");
    run_check("def", 0, 4);
    check("def_rdy", cfg_ready, 1);

    enable = 1'b0;
    step();
    check("dis_lk", locked, 0);
    check("dis_clk", outclk, 0);
    check("dis_tick", tick, 0);

    // IDLE write: ch1 div 5 -> high 2, low 3.
    write(2'd1, 5, 0);
    check("idlewr_lk", locked, 0);
    check("idlewr_rdy", cfg_ready, 1);
    m_div = '{2, 5, 2};
    settle("div5");
    run_check("div5", 0, 10);

    // RUN write: ch2 div 4 phase 2 -> realign.
    write(2'd2, 4, 2);
    check("rwr_lk", locked, 0);
    check("rwr_rdy", cfg_ready, 0);
    check("rwr_clk", outclk, 0);
    repeat (LOCK - 1) step();
    check("rwr_lk_last", locked, 0);
    step();
    m_div = '{2, 5, 4};
    m_ph  = '{0, 0, 2};
    check("realign_clk", outclk, 3'b011);
    check("realign_tick", tick, 3'b011);
    run_check("realign", 0, 3);

    // Out-of-range channel: accepted, nothing changes.
    write(2'd3, 7, 1);
    check("inv_rdy", cfg_ready, 1);
    run_check("inv", 3, 3);

    // Clamping: div 0/1 act as 2; phase 9 with div 6 acts as 5.
    enable = 1'b0;
    step();
    write(2'd0, 0, 0);
    write(2'd1, 1, 1);
    write(2'd2, 6, 9);
    m_div = '{2, 2, 6};
    m_ph  = '{0, 1, 5};
    settle("clamp");
    check("clamp_clk0", outclk, 3'b001);
    check("clamp_tick0", tick, 3'b001);
    run_check("clamp", 0, 8);

    // Enable drop mid-SETTLE aborts; re-enable takes the full settle.
    enable = 1'b0;
    step();
    enable = 1'b1;
    repeat (6) step();
    check("abort_rdy_mid", cfg_ready, 0);
    enable = 1'b0;
    step();
    check("abort_rdy", cfg_ready, 1);
    check("abort_lk", locked, 0);
    settle("restart");
    run_check("restart", 0, 2);

    // Asynchronous reset mid-RUN; configuration returns to defaults.
    @(posedge refclk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_clk", outclk, 0);
    check("arst_tick", tick, 0);
    check("arst_lk", locked, 0);
    check("arst_rdy", cfg_ready, 0);
    enable = 1'b0;
    @(negedge refclk);
    rst_n = 1'b1;
    step();
    m_div = '{2, 2, 2};
    m_ph  = '{0, 0, 0};
    settle("post_rst");
    run_check("post_rst", 0, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spw_clkgen_multi.md
# spw_clkgen_multi

Parametrised multi-channel clock-enable/clock generator with lock sequencing, built on a single reference clock. It produces NUM_CH divided square waves and matching single-cycle tick strobes, each with its own runtime-programmable divide ratio and phase offset. It drives the SpaceWire TX bit-rate and timeout logic where a fixed-ratio hard PLL output is not flexible enough. After every (re)configuration it holds all channels, settles, and realigns them before asserting `locked`.

## Interface
Parameters:
- NUM_CH, 4, number of output channels (1..16)
- DIV_W, 8, width of divide and phase fields
- LOCK_CYCLES, 16, settle length in refclk cycles (>=1)
- DEF_DIV, 2, divide ratio loaded into every channel at reset

Ports (CH_W = max(1, clog2(NUM_CH))):
- refclk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  run request; 0 forces IDLE
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  configuration accept window
- cfg_ch  in  CH_W  target channel
- cfg_div  in  DIV_W  period in refclk cycles
- cfg_phase  in  DIV_W  start count for channel after realign
- outclk  out  NUM_CH  divided square waves, registered
- tick  out  NUM_CH  one-cycle strobe at each outclk rising edge, registered
- locked  out  1  all channels running and aligned

## Operation
- Per channel i: registers div_i, phase_i, cnt_i. Effective div = max(div_i, 2). Effective phase = min(phase_i, div-1).
- RUN: cnt_i increments each cycle, wraps div-1 -> 0. outclk[i] = (cnt_i < div/2, floor); tick[i] = (cnt_i == 0). Odd div: high floor(div/2), low ceil(div/2).
- FSM states IDLE, SETTLE, RUN. Reset -> IDLE.
- IDLE: outclk=0, tick=0, locked=0, cfg_ready=1, counters held at effective phase. enable=1 -> SETTLE.
- SETTLE: cfg_ready=0, outputs 0, locked=0, counters held at effective phase; internal settle counter counts LOCK_CYCLES cycles, then -> RUN.
- RUN: counters run, locked=1, cfg_ready=1.
- enable=0 in any state -> IDLE next cycle (highest priority).
- Config transfer on cfg_valid && cfg_ready: div/phase of channel cfg_ch written. In IDLE: stay IDLE. In RUN: -> SETTLE, all channels reloaded to their phases (global realign). cfg_ch >= NUM_CH: transfer accepted, no register written, no state change.
- Simultaneous transfer and enable=0 in RUN: write applied, state -> IDLE.
- Settle counter cleared on every SETTLE entry; enable dropping mid-SETTLE aborts it.
- Reset values: outclk=0, tick=0, locked=0, cfg_ready=0 (state IDLE raises cfg_ready one cycle after rst_n release), div_i=DEF_DIV, phase_i=0, cnt_i=0.
- rst_n assertion mid-operation: all outputs to reset values immediately (asynchronous); configuration lost.

## Timing
- enable sampled 1 at edge E: SETTLE for cycles E+1..E+LOCK_CYCLES; first RUN cycle E+LOCK_CYCLES+1 with locked=1, cnt_i=effective phase, outputs reflecting that count in the same cycle (registered from next-state).
- Transfer at edge T in RUN: locked=0 and cfg_ready=0 from cycle T+1; RUN resumes at T+LOCK_CYCLES+1 with all channels aligned.
- enable=0 at edge E: locked, outclk, tick all 0 from cycle E+1.
- Divide change latency = LOCK_CYCLES+1 cycles; no glitch/runt pulses on outclk at any transition (outputs only low during SETTLE/IDLE).
- cfg_ready is a registered state decode; cfg_valid may be held, one transfer per ready cycle.

## Test plan
- Reset, enable=1, defaults (DEF_DIV=2, LOCK_CYCLES=16) -> locked rises exactly 17 cycles after enable sampled; every outclk toggles each cycle, tick every 2nd cycle, all channels aligned.
- In IDLE write ch1 div=5 phase=0, enable -> ch1 high 2 cycles, low 3, tick every 5 cycles coinciding with rising edge.
- In RUN write ch2 div=4 phase=2 -> locked low next cycle for 16 cycles; at resume ch2 starts at cnt=2 (outclk low, no tick), ch0 at cnt=0 (tick=1).
- div=0, div=1, phase=9 with div=6 -> behave as div=2, and phase 5.
- cfg_ch=NUM_CH in RUN -> cfg accepted, locked stays 1, no output change; enable drop mid-SETTLE -> IDLE next cycle, re-enable restarts full 16-cycle settle.
- rst_n pulse mid-RUN -> outputs and locked 0 asynchronously; divides back to DEF_DIV after re-lock.
